// File: rtl/modul_s_if.sv
// Signal bundle for the horizontal (S) traffic-light stage.
//   intretinere     : maintenance request, level (master -> slave)
//   Continuare_v_s  : handoff from the vertical stage (master -> slave)
//   buton_pieton    : pedestrian push-button, asynchronous (master -> slave)
//   Continuare_s_v  : handoff to the vertical stage (slave -> master)
//   Verde/Galben/Rosu_auto_S : car lamps (slave -> master)
//   Verde/Rosu_pieton        : pedestrian lamps (slave -> master)
interface modul_s_if;
  logic intretinere;
  logic Continuare_v_s;
  logic buton_pieton;
  logic Continuare_s_v;
  logic Verde_auto_S;
  logic Galben_auto_S;
  logic Rosu_auto_S;
  logic Verde_pieton;
  logic Rosu_pieton;

  modport master (
    output intretinere, Continuare_v_s, buton_pieton,
    input  Continuare_s_v, Verde_auto_S, Galben_auto_S, Rosu_auto_S,
           Verde_pieton, Rosu_pieton
  );

  modport slave (
    input  intretinere, Continuare_v_s, buton_pieton,
    output Continuare_s_v, Verde_auto_S, Galben_auto_S, Rosu_auto_S,
           Verde_pieton, Rosu_pieton
  );
endinterface

// File: rtl/modul_s.sv
// Horizontal-direction traffic-light controller with handoff to/from the
// vertical stage, optional pedestrian phase and maintenance blink mode.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : modul_s_if.slave (maintenance, handoff in/out, button, lamps)
// Parameters: SEC (clk cycles per tick), T_* state durations in ticks (>=1).
// Build option: define PIETON_EN to implement the pedestrian request path
// and the PIETONI phase; without it the button is ignored.
module modul_s #(
  parameter logic [23:0] SEC      = 24'd10000000,
  parameter logic [7:0]  T_START  = 8'd2,
  parameter logic [7:0]  T_GALBEN = 8'd2,
  parameter logic [7:0]  T_VERDE  = 8'd15,
  parameter logic [7:0]  T_STOP   = 8'd3,
  parameter logic [7:0]  T_PIETON = 8'd10
) (
  input  logic     clk,
  input  logic     reset,
  modul_s_if.slave bus
);

  typedef enum logic [2:0] {
    START, GALBEN, VERDE, GALBEN_STOP, PIETONI, PREDARE, ASTEPT, INTRETINERE
  } state_t;

  state_t      state, state_nx;
  logic [23:0] presc;
  logic [7:0]  timer;
  logic [7:0]  dur;
  logic        tick, timer_done;
  logic        intr_m, intr_s;
  logic        cv_prev, cv_rise, token;
  logic        blink;
  logic        ped_go;
  logic        v_nx, g_nx, r_nx, vp_nx, rp_nx, c_nx;
  logic        v_q, g_q, r_q, vp_q, rp_q, c_q;

  assign tick       = (presc == SEC - 24'd1);
  // Exit on the tick that brings the timer to the duration, so a state
  // lasts exactly dur*SEC cycles.
  assign timer_done = tick && (timer + 8'd1 == dur);
  assign cv_rise    = bus.Continuare_v_s & ~cv_prev;

`ifdef PIETON_EN
  logic but_m, but_s, but_d, ped_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      but_m   <= 1'b0;
      but_s   <= 1'b0;
      but_d   <= 1'b0;
      ped_req <= 1'b0;
    end else begin
      but_m <= bus.buton_pieton;
      but_s <= but_m;
      but_d <= but_s;
      if (state == INTRETINERE)
        ped_req <= 1'b0;
      else if (state_nx == PIETONI && state != PIETONI)
        ped_req <= 1'b0;
      else if (but_s && !but_d)
        ped_req <= 1'b1;
    end
  end

  assign ped_go = ped_req;
`else
  logic unused_button;
  assign unused_button = bus.buton_pieton;
  assign ped_go        = 1'b0;
`endif

  always_comb begin
    dur = 8'd1;
    case (state)
      START:       dur = T_START;
      GALBEN:      dur = T_GALBEN;
      VERDE:       dur = T_VERDE;
      GALBEN_STOP: dur = T_STOP;
      PIETONI:     dur = T_PIETON;
      default:     dur = 8'd1;
    endcase
  end

  always_comb begin
    state_nx = state;
    v_nx  = 1'b0;
    g_nx  = 1'b0;
    r_nx  = 1'b0;
    vp_nx = 1'b0;
    rp_nx = 1'b0;
    c_nx  = 1'b0;

    if (intr_s) begin
      state_nx = INTRETINERE;
    end else begin
      case (state)
        START:       if (timer_done) state_nx = GALBEN;
        GALBEN:      if (timer_done) state_nx = VERDE;
        VERDE:       if (timer_done) state_nx = GALBEN_STOP;
        GALBEN_STOP: if (timer_done) state_nx = ped_go ? PIETONI : PREDARE;
        PIETONI:     if (timer_done) state_nx = PREDARE;
        PREDARE:     if (timer_done) state_nx = ASTEPT;
        ASTEPT:      if (token)      state_nx = GALBEN;
        INTRETINERE: state_nx = START;
      endcase
    end

    case (state)
      START, ASTEPT:       begin r_nx = 1'b1; rp_nx = 1'b1; end
      GALBEN, GALBEN_STOP: begin g_nx = 1'b1; rp_nx = 1'b1; end
      VERDE:               begin v_nx = 1'b1; rp_nx = 1'b1; end
      PIETONI:             begin r_nx = 1'b1; vp_nx = 1'b1; end
      PREDARE:             begin r_nx = 1'b1; rp_nx = 1'b1; c_nx = 1'b1; end
      INTRETINERE:         g_nx = blink;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= START;
      presc   <= '0;
      timer   <= '0;
      intr_m  <= 1'b0;
      intr_s  <= 1'b0;
      cv_prev <= 1'b0;
      token   <= 1'b0;
      blink   <= 1'b1;
      v_q     <= 1'b0;
      g_q     <= 1'b0;
      r_q     <= 1'b1;
      vp_q    <= 1'b0;
      rp_q    <= 1'b1;
      c_q     <= 1'b0;
    end else begin
      state   <= state_nx;
      intr_m  <= bus.intretinere;
      intr_s  <= intr_m;
      cv_prev <= bus.Continuare_v_s;

      // Prescaler and timer restart together on every transition.
      if (state_nx != state) begin
        presc <= '0;
        timer <= '0;
      end else if (tick) begin
        presc <= '0;
        timer <= timer + 8'd1;
      end else begin
        presc <= presc + 24'd1;
      end

      // Consuming the token in ASTEPT takes priority over a coincident edge.
      if (state == INTRETINERE || (state == ASTEPT && token))
        token <= 1'b0;
      else if (cv_rise && (state == PREDARE || state == ASTEPT))
        token <= 1'b1;

      if (state != INTRETINERE)
        blink <= 1'b1;
      else if (tick)
        blink <= ~blink;

      v_q  <= v_nx;
      g_q  <= g_nx;
      r_q  <= r_nx;
      vp_q <= vp_nx;
      rp_q <= rp_nx;
      c_q  <= c_nx;
    end
  end

  assign bus.Verde_auto_S   = v_q;
  assign bus.Galben_auto_S  = g_q;
  assign bus.Rosu_auto_S    = r_q;
  assign bus.Verde_pieton   = vp_q;
  assign bus.Rosu_pieton    = rp_q;
  assign bus.Continuare_s_v = c_q;

endmodule

// File: tb/tb_modul_s.sv
// Testbench for modul_s (SEC=4, default durations). The driver plans each
// round at random and pushes the expected lamp segments (pattern + length in
// cycles); the monitor splits the observed output stream into segments and
// compares each one as it ends.
module tb_modul_s;
  localparam int SECT = 4;
  localparam int TS = 2, TG = 2, TV = 15, TST = 3, TP = 10;

  // Pattern bit order: {handoff, ped green, ped red, car green, car yellow, car red}
  localparam logic [5:0] P_RED     = 6'b001001;
  localparam logic [5:0] P_YEL     = 6'b001010;
  localparam logic [5:0] P_GRN     = 6'b001100;
  localparam logic [5:0] P_PED     = 6'b010001;
  localparam logic [5:0] P_HAND    = 6'b101001;
  localparam logic [5:0] P_BLK_ON  = 6'b000010;
  localparam logic [5:0] P_BLK_OFF = 6'b000000;

  typedef struct {
    logic [5:0] pat;
    int         len;
  } seg_t;

  seg_t exp_q[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  modul_s_if bus();

  modul_s #(
    .SEC(24'd4), .T_START(8'd2), .T_GALBEN(8'd2), .T_VERDE(8'd15),
    .T_STOP(8'd3), .T_PIETON(8'd10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic [5:0] obs;
  assign obs = {bus.Continuare_s_v, bus.Verde_pieton, bus.Rosu_pieton,
                bus.Verde_auto_S, bus.Galben_auto_S, bus.Rosu_auto_S};

  int n_checks = 0;
  int n_fail = 0;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void push_seg(logic [5:0] pat, int len);
    seg_t s;
    s.pat = pat;
    s.len = len;
    exp_q.push_back(s);
  endfunction

  // Monitor
  logic [5:0] cur_pat = '0;
  int         cur_len = 0;
  bit         run_on = 0;

  function automatic void close_seg();
    seg_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_segment: got pattern %b len %0d, expected none", cur_pat, cur_len);
    end else begin
      e = exp_q.pop_front();
      check("seg_pattern", int'(cur_pat), int'(e.pat));
      check("seg_length", cur_len, e.len);
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (run_on) begin
          close_seg();
          run_on = 0;
        end
        check("reset_outputs", int'(obs), int'(P_RED));
      end else begin
        check("no_green_conflict", int'(obs[4] & obs[2]), 0);
        if (!run_on) begin
          run_on  = 1;
          cur_pat = obs;
          cur_len = 1;
        end else if (obs == cur_pat) begin
          cur_len++;
        end else begin
          close_seg();
          cur_pat = obs;
          cur_len = 1;
        end
      end
    end
  end

  // Returns at the first falling edge where obs[idx] equals val.
  task automatic wait_bit(input int idx, input logic val, input int limit, input string what);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (obs[idx] !== val && n < limit);
    check(what, int'(obs[idx] === val), 1);
  endtask

  task automatic pulse_cv();
    #1 bus.Continuare_v_s = 1'b1;
    @(negedge clk);
    #1 bus.Continuare_v_s = 1'b0;
  endtask

  // kind: 0 handoff pulse in ASTEPT, 1 pulse during PREDARE, 2 maintenance
  // during VERDE, 3 reset during PREDARE, 4 final (stay in ASTEPT)
  task automatic run_round(input int kind);
    bit press, spur, on;
    int d1, d, k, m, h, rem;
    press = 1'($urandom_range(0, 1));
    spur  = 1'($urandom_range(0, 1));
    d1    = $urandom_range(0, 30);
    d     = $urandom_range(0, 5);
    k     = $urandom_range(0, 2);
    m     = $urandom_range(0, 50);
    h     = $urandom_range(8, 30);

    push_seg(P_YEL, TG * SECT);
    if (kind == 2) begin
      // Two sync stages plus one state edge before the lamps follow.
      push_seg(P_GRN, m + 4);
      rem = h;
      on  = 1;
      while (rem > 0) begin
        push_seg(on ? P_BLK_ON : P_BLK_OFF, (rem > 4) ? 4 : rem);
        rem -= 4;
        on = !on;
      end
      push_seg(P_RED, TS * SECT);
      wait_bit(2, 1'b1, 200, "wait_verde");
      repeat (m) @(negedge clk);
      #1 bus.intretinere = 1'b1;
      repeat (h) @(negedge clk);
      #1 bus.intretinere = 1'b0;
    end else begin
      push_seg(P_GRN, TV * SECT);
      push_seg(P_YEL, TST * SECT);
`ifdef PIETON_EN
      if (press) push_seg(P_PED, TP * SECT);
`endif
      if (kind == 3) begin
        push_seg(P_HAND, k + 1);
        // Reset value equals the START pattern, so one extra cycle shows.
        push_seg(P_RED, TS * SECT + 1);
      end else begin
        push_seg(P_HAND, SECT);
      end
      if (kind == 0) push_seg(P_RED, d + 3);
      else if (kind == 1) push_seg(P_RED, 1);

      wait_bit(2, 1'b1, 200, "wait_verde");
      repeat (d1) @(negedge clk);
      if (press) begin
        #1 bus.buton_pieton = 1'b1;
        repeat (3) @(negedge clk);
        #1 bus.buton_pieton = 1'b0;
      end
      if (spur) begin
        repeat (2) @(negedge clk);
        pulse_cv();
      end
      wait_bit(5, 1'b1, 300, "wait_handoff");
      case (kind)
        0: begin
          wait_bit(5, 1'b0, 20, "wait_astept");
          repeat (d) @(negedge clk);
          pulse_cv();
        end
        1: begin
          repeat (k) @(negedge clk);
          pulse_cv();
        end
        3: begin
          repeat (k) @(negedge clk);
          #1 reset = 1'b0;
          repeat (2) @(negedge clk);
          @(posedge clk);
          #2 reset = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    int kinds[9];
    kinds = '{0, 1, 2, 0, 3, 1, 2, 0, 4};
    bus.intretinere    = 1'b0;
    bus.Continuare_v_s = 1'b0;
    bus.buton_pieton   = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    push_seg(P_RED, TS * SECT + 1);

    foreach (kinds[i]) run_round(kinds[i]);

    wait_bit(5, 1'b0, 20, "wait_final_astept");
    repeat (100) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("final_astept_pattern", int'(cur_pat), int'(P_RED));
    check("final_astept_held", int'(cur_len >= 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
